// File: rtl/xfer_seq_if.sv
// Handshake bundle between the transaction sequencer and its CMD/DAT/ADMA/host neighbours.
// master = the sequencer, slave = the engines and host register block around it.
interface xfer_seq_if;
  logic        start_flag;
  logic [5:0]  cmd_index_in;
  logic        data_present;
  logic        multiple_blk;
  logic [15:0] block_count;
  logic        cmd_complete;
  logic        cmd_timeout;
  logic        blk_done;
  logic        dat_error;
  logic        abort_req;

  logic        new_cmd;
  logic [5:0]  cmd_index_out;
  logic        dat_start;
  logic        dma_start;
  logic        busy;
  logic [15:0] blocks_left;
  logic        xfer_complete;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic        start_rejected;

  modport master (
    input  start_flag, cmd_index_in, data_present, multiple_blk, block_count,
           cmd_complete, cmd_timeout, blk_done, dat_error, abort_req,
    output new_cmd, cmd_index_out, dat_start, dma_start, busy, blocks_left,
           xfer_complete, err_pulse, err_code, start_rejected
  );

  modport slave (
    output start_flag, cmd_index_in, data_present, multiple_blk, block_count,
           cmd_complete, cmd_timeout, blk_done, dat_error, abort_req,
    input  new_cmd, cmd_index_out, dat_start, dma_start, busy, blocks_left,
           xfer_complete, err_pulse, err_code, start_rejected
  );
endinterface

// File: rtl/xfer_sequencer.sv
// Sequences one SD transaction: command, data phase with watchdog, optional CMD12 stop.
// Define XFER_SEQ_AUTO_CMD12_EN to issue CMD12 automatically after multi-block data and on abort.
module xfer_sequencer #(
  parameter int unsigned       WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input logic        CLK,
  input logic        rst_L,
  xfer_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_CMD, WAIT_RSP, DATA, ISSUE_STOP, WAIT_STOP, DONE, ERROR
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD_TO  = 3'd1,
    ERR_DAT     = 3'd2,
    ERR_WDOG    = 3'd3,
    ERR_ZERO    = 3'd4,
    ERR_ABORT   = 3'd5,
    ERR_STOP_TO = 3'd6
  } err_e;

  localparam logic [5:0] STOP_CMD_IDX = 6'd12;

  // Reset asserts asynchronously but is released on a clock edge.
  logic rst_meta_n, rst_sync_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) {rst_sync_n, rst_meta_n} <= 2'b00;
    else        {rst_sync_n, rst_meta_n} <= {rst_meta_n, 1'b1};
  end

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic [5:0]          idx_q, idx_d;
  logic                data_q, data_d;
  logic                multi_q, multi_d;
  logic                abort_q, abort_d;
  logic [15:0]         blocks_q, blocks_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic                new_cmd_q, dat_start_q, busy_q, cplt_q, err_pulse_q, rej_q;
  logic [5:0]          cmd_idx_out_q;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    idx_d    = idx_q;
    data_d   = data_q;
    multi_d  = multi_q;
    abort_d  = abort_q;
    blocks_d = blocks_q;
    wdog_d   = wdog_q;

    case (state_q)
      IDLE: begin
        if (bus.start_flag) begin
          err_d    = ERR_NONE;
          idx_d    = bus.cmd_index_in;
          data_d   = bus.data_present;
          multi_d  = bus.multiple_blk;
          abort_d  = 1'b0;
          blocks_d = bus.multiple_blk ? bus.block_count : 16'd1;
          if (bus.data_present && bus.multiple_blk && (bus.block_count == 16'd0)) begin
            state_d = ERROR;
            err_d   = ERR_ZERO;
          end else begin
            state_d = ISSUE_CMD;
          end
        end
      end
      ISSUE_CMD: state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (bus.cmd_timeout) begin
          state_d = ERROR;
          err_d   = ERR_CMD_TO;
        end else if (bus.cmd_complete) begin
          state_d = data_q ? DATA : DONE;
          wdog_d  = '0;
        end
      end
      DATA: begin
        if (bus.dat_error) begin
          state_d = ERROR;
          err_d   = ERR_DAT;
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = ERROR;
          err_d   = ERR_WDOG;
        end else if (bus.abort_req) begin
`ifdef XFER_SEQ_AUTO_CMD12_EN
          state_d = ISSUE_STOP;
          abort_d = 1'b1;
`else
          state_d = ERROR;
          err_d   = ERR_ABORT;
`endif
        end else if (bus.blk_done) begin
          wdog_d = '0;
          if (blocks_q != 16'd0) begin
            blocks_d = blocks_q - 16'd1;
            if (blocks_q == 16'd1) begin
`ifdef XFER_SEQ_AUTO_CMD12_EN
              state_d = multi_q ? ISSUE_STOP : DONE;
`else
              state_d = DONE;
`endif
            end
          end
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ISSUE_STOP: state_d = WAIT_STOP;
      WAIT_STOP: begin
        if (bus.cmd_timeout) begin
          state_d = ERROR;
          err_d   = ERR_STOP_TO;
        end else if (bus.cmd_complete) begin
          state_d = abort_q ? ERROR : DONE;
          if (abort_q) err_d = ERR_ABORT;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so they line up with the state they describe.
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q       <= IDLE;
      err_q         <= ERR_NONE;
      idx_q         <= '0;
      data_q        <= 1'b0;
      multi_q       <= 1'b0;
      abort_q       <= 1'b0;
      blocks_q      <= '0;
      wdog_q        <= '0;
      new_cmd_q     <= 1'b0;
      cmd_idx_out_q <= '0;
      dat_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      cplt_q        <= 1'b0;
      err_pulse_q   <= 1'b0;
      rej_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      multi_q       <= multi_d;
      abort_q       <= abort_d;
      blocks_q      <= blocks_d;
      wdog_q        <= wdog_d;
      new_cmd_q     <= (state_d == ISSUE_CMD) || (state_d == ISSUE_STOP);
      cmd_idx_out_q <= (state_d == ISSUE_CMD)  ? idx_d :
                       (state_d == ISSUE_STOP) ? STOP_CMD_IDX : 6'd0;
      dat_start_q   <= (state_q == WAIT_RSP) && (state_d == DATA);
      busy_q        <= (state_d != IDLE);
      cplt_q        <= (state_d == DONE);
      err_pulse_q   <= (state_d == ERROR);
      rej_q         <= bus.start_flag && (state_q != IDLE);
    end
  end

  assign bus.new_cmd        = new_cmd_q;
  assign bus.cmd_index_out  = cmd_idx_out_q;
  assign bus.dat_start      = dat_start_q;
  assign bus.dma_start      = dat_start_q;
  assign bus.busy           = busy_q;
  assign bus.blocks_left    = blocks_q;
  assign bus.xfer_complete  = cplt_q;
  assign bus.err_pulse      = err_pulse_q;
  assign bus.err_code       = err_q;
  assign bus.start_rejected = rej_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed bench for xfer_sequencer: each scenario writes the expected output timeline
// (per-cycle pulses and held levels) and one compare process checks the DUT every cycle.
module tb_xfer_sequencer;

  localparam int MAXC = 512;

  logic CLK   = 1'b0;
  logic rst_L = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_new_seen = 0;
  int   n_dat_seen = 0;

  xfer_seq_if bus_if ();

  xfer_sequencer #(.WDOG_W(16), .WDOG_LIMIT(16'd16)) dut (
    .CLK   (CLK),
    .rst_L (rst_L),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number.
  logic        e_valid [MAXC];
  logic        e_new   [MAXC];
  logic [5:0]  e_idx   [MAXC];
  logic        e_dat   [MAXC];
  logic        e_busy  [MAXC];
  logic [15:0] e_blk   [MAXC];
  logic        e_cplt  [MAXC];
  logic        e_err   [MAXC];
  logic [2:0]  e_code  [MAXC];
  logic        e_rej   [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
  endtask

  task automatic hold_blk(input int c, input logic [15:0] v);
    for (int i = c; i < MAXC; i++) e_blk[i] = v;
  endtask

  task automatic hold_code(input int c, input logic [2:0] v);
    for (int i = c; i < MAXC; i++) e_code[i] = v;
  endtask

  task automatic drive_start(input logic [5:0] idx, input logic dp, input logic mb, input logic [15:0] cnt);
    bus_if.cmd_index_in = idx;
    bus_if.data_present = dp;
    bus_if.multiple_blk = mb;
    bus_if.block_count  = cnt;
    bus_if.start_flag   = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (cyc < MAXC && e_valid[cyc]) begin
      check("new_cmd",        bus_if.new_cmd,        e_new[cyc]);
      if (e_new[cyc]) check("cmd_index_out", bus_if.cmd_index_out, e_idx[cyc]);
      check("dat_start",      bus_if.dat_start,      e_dat[cyc]);
      check("dma_start",      bus_if.dma_start,      e_dat[cyc]);
      check("busy",           bus_if.busy,           e_busy[cyc]);
      check("blocks_left",    bus_if.blocks_left,    e_blk[cyc]);
      check("xfer_complete",  bus_if.xfer_complete,  e_cplt[cyc]);
      check("err_pulse",      bus_if.err_pulse,      e_err[cyc]);
      check("err_code",       bus_if.err_code,       e_code[cyc]);
      check("start_rejected", bus_if.start_rejected, e_rej[cyc]);
    end
    if (bus_if.new_cmd === 1'b1)   n_new_seen++;
    if (bus_if.dat_start === 1'b1) n_dat_seen++;
  end

  initial begin
    int n;
    int nc0;
    int nd0;

    for (int i = 0; i < MAXC; i++) begin
      e_valid[i] = (i >= 1);
      e_new[i] = 1'b0; e_idx[i] = '0; e_dat[i] = 1'b0; e_busy[i] = 1'b0;
      e_blk[i] = '0; e_cplt[i] = 1'b0; e_err[i] = 1'b0; e_code[i] = '0; e_rej[i] = 1'b0;
    end
    bus_if.start_flag = 1'b0; bus_if.cmd_index_in = '0; bus_if.data_present = 1'b0;
    bus_if.multiple_blk = 1'b0; bus_if.block_count = '0; bus_if.cmd_complete = 1'b0;
    bus_if.cmd_timeout = 1'b0; bus_if.blk_done = 1'b0; bus_if.dat_error = 1'b0;
    bus_if.abort_req = 1'b0;

    wait_to(3);
    rst_L = 1'b1;
    wait_to(6);
    check("reset_busy",   bus_if.busy,        0);
    check("reset_blocks", bus_if.blocks_left, 0);
    check("reset_code",   bus_if.err_code,    0);

    // 1: command without data; stray blk_done in WAIT_RSP is ignored.
    wait_to(8); n = cyc; nc0 = n_new_seen; nd0 = n_dat_seen;
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd8; hold_blk(n+1, 16'd1);
    set_busy(n+1, n+7); e_cplt[n+7] = 1'b1;
    drive_start(6'd8, 1'b0, 1'b0, 16'd7);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+3); bus_if.blk_done = 1'b1;
    wait_to(n+4); bus_if.blk_done = 1'b0;
    wait_to(n+6); bus_if.cmd_complete = 1'b1;
    wait_to(n+7); bus_if.cmd_complete = 1'b0;
    wait_to(n+10);
    check("t1_new_cmd_count",   n_new_seen - nc0, 1);
    check("t1_dat_start_count", n_dat_seen - nd0, 0);

    // 2: three-block read; stray cmd_complete during DATA is ignored.
    n = cyc; nc0 = n_new_seen; nd0 = n_dat_seen;
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd18; hold_blk(n+1, 16'd3);
    e_dat[n+4] = 1'b1;
    hold_blk(n+7, 16'd2); hold_blk(n+9, 16'd1); hold_blk(n+11, 16'd0);
`ifdef XFER_SEQ_AUTO_CMD12_EN
    e_new[n+11] = 1'b1; e_idx[n+11] = 6'd12; e_cplt[n+15] = 1'b1; set_busy(n+1, n+15);
`else
    e_cplt[n+11] = 1'b1; set_busy(n+1, n+11);
`endif
    drive_start(6'd18, 1'b1, 1'b1, 16'd3);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+3); bus_if.cmd_complete = 1'b1;
    wait_to(n+4); bus_if.cmd_complete = 1'b0;
    check("t2_blocks_first", bus_if.blocks_left, 3);
    wait_to(n+5); bus_if.cmd_complete = 1'b1;
    wait_to(n+6); bus_if.cmd_complete = 1'b0; bus_if.blk_done = 1'b1;
    wait_to(n+7); bus_if.blk_done = 1'b0;
    check("t2_blocks_after1", bus_if.blocks_left, 2);
    wait_to(n+8); bus_if.blk_done = 1'b1;
    wait_to(n+9); bus_if.blk_done = 1'b0;
    check("t2_blocks_after2", bus_if.blocks_left, 1);
    wait_to(n+10); bus_if.blk_done = 1'b1;
    wait_to(n+11); bus_if.blk_done = 1'b0;
    check("t2_blocks_after3", bus_if.blocks_left, 0);
`ifdef XFER_SEQ_AUTO_CMD12_EN
    wait_to(n+14); bus_if.cmd_complete = 1'b1;
    wait_to(n+15); bus_if.cmd_complete = 1'b0;
    wait_to(n+18);
    check("t2_new_cmd_count", n_new_seen - nc0, 2);
`else
    wait_to(n+18);
    check("t2_new_cmd_count", n_new_seen - nc0, 1);
`endif
    check("t2_dat_start_count", n_dat_seen - nd0, 1);

    // 3: timeout and response in the same cycle; timeout wins.
    n = cyc; nd0 = n_dat_seen;
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd17; hold_blk(n+1, 16'd1);
    set_busy(n+1, n+4); e_err[n+4] = 1'b1; hold_code(n+4, 3'd1);
    drive_start(6'd17, 1'b1, 1'b0, 16'd0);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+3); bus_if.cmd_complete = 1'b1; bus_if.cmd_timeout = 1'b1;
    wait_to(n+4); bus_if.cmd_complete = 1'b0; bus_if.cmd_timeout = 1'b0;
    wait_to(n+8);
    check("t3_err_code_held",   bus_if.err_code, 1);
    check("t3_dat_start_count", n_dat_seen - nd0, 0);

    // 4a: no blk_done; watchdog reaches 16 on the 17th DATA cycle.
    n = cyc;
    hold_code(n+1, 3'd0);
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd17; hold_blk(n+1, 16'd1);
    e_dat[n+3] = 1'b1; set_busy(n+1, n+20); e_err[n+20] = 1'b1; hold_code(n+20, 3'd3);
    drive_start(6'd17, 1'b1, 1'b0, 16'd0);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+2); bus_if.cmd_complete = 1'b1;
    wait_to(n+3); bus_if.cmd_complete = 1'b0;
    wait_to(n+24);
    check("t4_wdog_code", bus_if.err_code, 3);

    // 4b: blk_done together with dat_error; error wins, no decrement.
    n = cyc;
    hold_code(n+1, 3'd0);
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd18; hold_blk(n+1, 16'd2);
    e_dat[n+3] = 1'b1; set_busy(n+1, n+6); e_err[n+6] = 1'b1; hold_code(n+6, 3'd2);
    drive_start(6'd18, 1'b1, 1'b1, 16'd2);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+2); bus_if.cmd_complete = 1'b1;
    wait_to(n+3); bus_if.cmd_complete = 1'b0;
    wait_to(n+5); bus_if.blk_done = 1'b1; bus_if.dat_error = 1'b1;
    wait_to(n+6); bus_if.blk_done = 1'b0; bus_if.dat_error = 1'b0;
    wait_to(n+9);
    check("t4_blocks_kept", bus_if.blocks_left, 2);

    // 5a: start during DATA is rejected and leaves the transfer alone.
    n = cyc;
    hold_code(n+1, 3'd0);
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd24; hold_blk(n+1, 16'd1);
    e_dat[n+3] = 1'b1; e_rej[n+5] = 1'b1; hold_blk(n+7, 16'd0);
    e_cplt[n+7] = 1'b1; set_busy(n+1, n+7);
    drive_start(6'd24, 1'b1, 1'b0, 16'd0);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+2); bus_if.cmd_complete = 1'b1;
    wait_to(n+3); bus_if.cmd_complete = 1'b0;
    wait_to(n+4); drive_start(6'd40, 1'b0, 1'b1, 16'd9);
    wait_to(n+5); bus_if.start_flag = 1'b0;
    wait_to(n+6); bus_if.blk_done = 1'b1;
    wait_to(n+7); bus_if.blk_done = 1'b0;
    wait_to(n+10);
    check("t5_blocks_not_relatched", bus_if.blocks_left, 0);

    // Abort during a four-block transfer after one block.
    n = cyc;
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd25; hold_blk(n+1, 16'd4);
    e_dat[n+3] = 1'b1; hold_blk(n+5, 16'd3);
`ifdef XFER_SEQ_AUTO_CMD12_EN
    e_new[n+7] = 1'b1; e_idx[n+7] = 6'd12;
    set_busy(n+1, n+10); e_err[n+10] = 1'b1; hold_code(n+10, 3'd5);
`else
    set_busy(n+1, n+7); e_err[n+7] = 1'b1; hold_code(n+7, 3'd5);
`endif
    drive_start(6'd25, 1'b1, 1'b1, 16'd4);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+2); bus_if.cmd_complete = 1'b1;
    wait_to(n+3); bus_if.cmd_complete = 1'b0;
    wait_to(n+4); bus_if.blk_done = 1'b1;
    wait_to(n+5); bus_if.blk_done = 1'b0;
    wait_to(n+6); bus_if.abort_req = 1'b1;
    wait_to(n+7); bus_if.abort_req = 1'b0;
`ifdef XFER_SEQ_AUTO_CMD12_EN
    wait_to(n+9); bus_if.cmd_complete = 1'b1;
    wait_to(n+10); bus_if.cmd_complete = 1'b0;
`endif
    wait_to(n+13);
    check("abort_code", bus_if.err_code, 5);

    // 5b: zero block count on a multi-block data command.
    n = cyc; nc0 = n_new_seen;
    hold_code(n+1, 3'd4); hold_blk(n+1, 16'd0); set_busy(n+1, n+1); e_err[n+1] = 1'b1;
    drive_start(6'd30, 1'b1, 1'b1, 16'd0);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+5);
    check("t5_zero_no_new_cmd", n_new_seen - nc0, 0);

    // 6: reset during WAIT_RSP, then a normal command.
    n = cyc;
    hold_code(n+1, 3'd0);
    e_new[n+1] = 1'b1; e_idx[n+1] = 6'd9; hold_blk(n+1, 16'd1); set_busy(n+1, n+3);
    hold_blk(n+4, 16'd0);
    e_new[n+13] = 1'b1; e_idx[n+13] = 6'd5; hold_blk(n+13, 16'd1);
    set_busy(n+13, n+15); e_cplt[n+15] = 1'b1;
    drive_start(6'd9, 1'b1, 1'b0, 16'd0);
    wait_to(n+1); bus_if.start_flag = 1'b0;
    wait_to(n+3);
    #2 rst_L = 1'b0;
    #1;
    check("t6_rst_busy",    bus_if.busy,        0);
    check("t6_rst_blocks",  bus_if.blocks_left, 0);
    check("t6_rst_new_cmd", bus_if.new_cmd,     0);
    check("t6_rst_cmd_idx", bus_if.cmd_index_out, 0);
    wait_to(n+6); rst_L = 1'b1;
    wait_to(n+12); drive_start(6'd5, 1'b0, 1'b0, 16'd0);
    wait_to(n+13); bus_if.start_flag = 1'b0;
    wait_to(n+14); bus_if.cmd_complete = 1'b1;
    wait_to(n+15); bus_if.cmd_complete = 1'b0;
    wait_to(n+19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
